// File: rtl/alu_pkg.sv
// Shared ALU select codes, legality check and arbiter FSM encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_PASS = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_PASS: is_legal_op = 1'b1;
      default:                     is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: prio picks the winner only when both request.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between EXU (port 0) and LSU/AGU (port 1).
// Optional ALU_ILLEGAL_CHECK_EN: illegal select codes run as ADD, return 0 and flag resp_err.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp_err,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  state_t           state_reg;
  logic             prio_reg;
  logic             owner_reg;
  logic             err_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;

  logic [1:0]       grant;
  logic             idle;
  logic             accept;
  logic [3:0]       in_op;
  logic [3:0]       op_next;
  logic             err_next;
  logic             owner_resp_ready;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio_reg),
    .grant (grant)
  );

  assign idle       = (state_reg == IDLE);
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign accept     = req0_ready | req1_ready;
  assign in_op      = grant[1] ? req1_op : req0_op;

`ifdef ALU_ILLEGAL_CHECK_EN
  // Illegal codes are sanitised at capture so the ALU never sees them.
  assign err_next = ~is_legal_op(in_op);
  assign op_next  = err_next ? ALU_ADD : in_op;
`else
  assign err_next = 1'b0;
  assign op_next  = in_op;
`endif

  assign owner_resp_ready = owner_reg ? resp1_ready : resp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'b0;
      owner_reg  <= 1'b0;
      err_reg    <= 1'b0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg    <= op_next;
            a_reg     <= grant[1] ? req1_a : req0_a;
            b_reg     <= grant[1] ? req1_b : req0_b;
            owner_reg <= grant[1];
            err_reg   <= err_next;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          result_reg <= err_reg ? '0 : alu_result;
          state_reg  <= RESP;
        end
        RESP: begin
          if (owner_resp_ready) begin
            prio_reg  <= ~owner_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_sel      = op_reg;
  assign alu_a        = a_reg;
  assign alu_b        = b_reg;
  assign resp0_valid  = (state_reg == RESP) & ~owner_reg;
  assign resp1_valid  = (state_reg == RESP) & owner_reg;
  assign resp0_result = result_reg;
  assign resp1_result = result_reg;
  assign resp_err     = (state_reg == RESP) & err_reg;
  assign busy         = ~idle;

endmodule
